// File: rtl/instruction_streamer_pkg.sv
// Shared opcode constants, FSM state type and instruction-width helpers for the
// instruction streamer and its FIFOs.
package instruction_streamer_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_READ = 4'b0011;
    localparam logic [3:0] OP_WAIT = 4'b1111;

    typedef enum logic {
        ST_RUN,
        ST_WAIT
    } state_e;

    function automatic int ins_field_w(input int depth);
        return (depth > 2) ? depth : 2;
    endfunction

    function automatic int ins_last_w(input int depth, input int w);
        return ((1 << depth) > w) ? (1 << depth) : w;
    endfunction

    // Instruction word layout: {opcode[4], ins1[2], ins2[INSW], ins3[INSW], insLast[INSD]}
    function automatic int ins_width(input int depth, input int w);
        return 4 + 2 + 2 * ins_field_w(depth) + ins_last_w(depth, w);
    endfunction

endpackage

// File: rtl/instruction_streamer_sync_fifo.sv
// First-word fall-through synchronous FIFO with extra-MSB wrap pointers; used for
// both the instruction input queue and the read-result queue.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int LOG2  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [LOG2:0]    count
);

    localparam int ENTRIES = 1 << LOG2;

    logic [LOG2:0]      wr_ptr_q, wr_ptr_d;
    logic [LOG2:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]   mem_q [ENTRIES];
    logic               full;
    logic               do_push;
    logic               do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[LOG2] != rd_ptr_q[LOG2]) &&
                     (wr_ptr_q[LOG2-1:0] == rd_ptr_q[LOG2-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[LOG2-1:0]];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + (LOG2+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (LOG2+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[LOG2-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/instruction_streamer.sv
// Instruction issue front-end: queues host instructions, issues one per cycle (or NOP),
// handles WAIT stalls and captures READ results with guaranteed result-FIFO space.
module instruction_streamer
    import instruction_streamer_pkg::*;
#(
    parameter int         DEPTH     = 3,
    parameter int         W         = 16,
    parameter logic [3:0] READ_OP   = OP_READ,
    parameter logic [3:0] WAIT_OP   = OP_WAIT,
    parameter logic [3:0] NOP_OP    = OP_NOP,
    parameter int         READ_LAT  = 1,
    parameter int         IF_LOG2   = 2,
    parameter int         RF_LOG2   = 2,
    localparam int        INSD      = ins_last_w(DEPTH, W),
    localparam int        INS_WIDTH = ins_width(DEPTH, W)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INS_WIDTH-1:0]   in_ins,
    output logic [INS_WIDTH-1:0]   ins_out,
    input  logic [W-1:0]           acc_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [INS_WIDTH+W-1:0] res_data,
    output logic                   busy,
    output logic [15:0]            issue_cnt
);

    localparam logic [INS_WIDTH-1:0] NOP_WORD   = {NOP_OP, {(INS_WIDTH-4){1'b0}}};
    localparam logic [IF_LOG2:0]     IF_ENTRIES = (IF_LOG2+1)'(1 << IF_LOG2);
    localparam int                   RF_ENTRIES = 1 << RF_LOG2;

    state_e               state_q, state_d;
    logic [INSD-1:0]      wait_cnt_q, wait_cnt_d;
    logic [INS_WIDTH-1:0] ins_out_q, ins_out_d;
    logic [15:0]          issue_cnt_q, issue_cnt_d;
    logic [READ_LAT-1:0]  pipe_valid_q, pipe_valid_d;
    logic [INS_WIDTH-1:0] pipe_ins_q [READ_LAT];
    logic [INS_WIDTH-1:0] pipe_ins_d [READ_LAT];

    logic [INS_WIDTH-1:0] if_head;
    logic                 if_empty;
    logic                 if_pop;
    logic [IF_LOG2:0]     if_count;
    logic                 rf_empty;
    logic                 rf_push;
    logic [RF_LOG2:0]     rf_count;
    logic [3:0]           head_op;
    logic [INSD-1:0]      head_last;
    logic                 read_ok;
    logic                 issue_read;
    int                   inflight;

    assign head_op   = if_head[INS_WIDTH-1 -: 4];
    assign head_last = if_head[INSD-1:0];
    assign in_ready  = (if_count != IF_ENTRIES);
    assign res_valid = !rf_empty;
    assign rf_push   = pipe_valid_q[READ_LAT-1];
    assign ins_out   = ins_out_q;
    assign issue_cnt = issue_cnt_q;
    assign busy      = !if_empty || (state_q == ST_WAIT) || (|pipe_valid_q);

    sync_fifo #(.WIDTH(INS_WIDTH), .LOG2(IF_LOG2)) u_in_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push    (in_valid && in_ready),
        .wr_data (in_ins),
        .pop     (if_pop),
        .rd_data (if_head),
        .empty   (if_empty),
        .count   (if_count)
    );

    sync_fifo #(.WIDTH(INS_WIDTH + W), .LOG2(RF_LOG2)) u_res_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push    (rf_push),
        .wr_data ({pipe_ins_q[READ_LAT-1], acc_data}),
        .pop     (res_ready),
        .rd_data (res_data),
        .empty   (rf_empty),
        .count   (rf_count)
    );

    // A READ may only go out if every read already in flight still has a slot reserved.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight = inflight + int'(pipe_valid_q[i]);
        end
        read_ok = (RF_ENTRIES - int'(rf_count)) > inflight;
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        ins_out_d   = NOP_WORD;
        issue_cnt_d = issue_cnt_q;
        if_pop      = 1'b0;
        issue_read  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!if_empty) begin
                    if (head_op == WAIT_OP) begin
                        if_pop     = 1'b1;
                        wait_cnt_d = head_last;
                        if (head_last != '0) begin
                            state_d = ST_WAIT;
                        end
                    end else if (head_op != READ_OP || read_ok) begin
                        if_pop     = 1'b1;
                        ins_out_d  = if_head;
                        issue_read = (head_op == READ_OP);
                        if (head_op != NOP_OP) begin
                            issue_cnt_d = issue_cnt_q + 16'd1;
                        end
                    end
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q - INSD'(1);
                if (wait_cnt_q == INSD'(1)) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pipe_valid_d = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            pipe_ins_d[i] = '0;
        end
        pipe_valid_d[0] = issue_read;
        pipe_ins_d[0]   = if_head;
        for (int i = 1; i < READ_LAT; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_ins_d[i]   = pipe_ins_q[i-1];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_RUN;
            wait_cnt_q   <= '0;
            ins_out_q    <= NOP_WORD;
            issue_cnt_q  <= '0;
            pipe_valid_q <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_ins_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            ins_out_q    <= ins_out_d;
            issue_cnt_q  <= issue_cnt_d;
            pipe_valid_q <= pipe_valid_d;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_ins_q[i] <= pipe_ins_d[i];
            end
        end
    end

endmodule
